// File: rtl/regfile_mp_pkg.sv
// Shared defaults and state encoding for the multi-port integer register file.
package regfile_mp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Pipeline-to-register-file bus: decode read ports, writeback write port, issue scoreboard, flush.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic                flush;
    logic                ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr, flush,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr, flush,
        output rd_data, rd_busy, ready
    );

endinterface

// File: rtl/regfile_mp_clear_ctrl.sv
// Clear sequencer: walks every array entry after reset or flush, then raises ready.
// Latency: exactly NREGS edges in CLEAR; ready is a decode of the registered state.
// Backpressure: none; flush is honoured only in READY, so a running clear is never restarted.
module rf_clear_ctrl
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    output logic          ready,
    output logic          clear_we,
    output logic [AW-1:0] clear_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    rf_state_e     state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clear_we    = 1'b0;
        ready       = 1'b0;
        case (state)
            CLEAR: begin
                clear_we    = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (flush) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign clear_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write forwarding, hardwired zero and busy scoreboard.
// Latency: 1 cycle address-to-data/busy on every read port; writes forward on the same edge.
// Backpressure: none; writes and busy sets are dropped while ready is low or on a flush edge.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  rf
);

    logic             ready;
    logic             clear_we;
    logic [AW-1:0]    clear_addr;
    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic             wr_acc;
    logic             set_acc;

    rf_clear_ctrl #(.NREGS(NREGS)) u_clear_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (rf.flush),
        .ready      (ready),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign rf.ready = ready;

    // A flush edge drops any write or set arriving with it.
    assign wr_acc  = ready && !rf.flush && rf.wr_en
                     && !(ZERO_REG && rf.wr_addr == '0);
    assign set_acc = ready && !rf.flush && rf.busy_set
                     && !(ZERO_REG && rf.busy_addr == '0);

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_acc) begin
            mem[rf.wr_addr] <= rf.wr_data;
        end
    end

    // Set is applied after the write-clear so it wins on a shared address.
    always_comb begin
        busy_nxt = busy;
        if (ready && rf.flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_acc)  busy_nxt[rf.wr_addr]   = 1'b0;
            if (set_acc) busy_nxt[rf.busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_nxt;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign addr = rf.rd_addr[p*AW +: AW];

        always_comb begin
            data_nxt = mem[addr];
            if (!ready || (ZERO_REG && addr == '0)) begin
                data_nxt = '0;
            end else if (wr_acc && rf.wr_addr == addr) begin
                data_nxt = rf.wr_data;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_nxt;
                busy_q <= busy_nxt[addr];
            end
        end

        assign rf.rd_data[p*XLEN +: XLEN] = data_q;
        assign rf.rd_busy[p]              = busy_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset/clear timing, forwarding, zero register, scoreboard, flush.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int BOUND = 100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.busy_set = 1'b0;
        bus.flush    = 1'b0;
    endtask

    // Count edges until ready; an expired bound reports BOUND, which fails the 32 check.
    task automatic wait_ready(output int edges);
        edges = 0;
        while (!bus.ready && edges < BOUND) begin
            tick();
            edges++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = 0; r < NREGS; r += 2) begin
            set_rd(5'(r), 5'(r + 1));
            tick();
            chk({tag, "_data"}, 64'(bus.rd_data), 64'h0);
            chk({tag, "_busy"}, 64'(bus.rd_busy), 64'h0);
        end
    endtask

    initial begin
        bus.rd_addr   = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.busy_addr = '0;
        idle();

        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(bus.ready), 64'h0);
        chk("rst_data",  64'(bus.rd_data), 64'h0);
        chk("rst_busy",  64'(bus.rd_busy), 64'h0);

        // Clear after reset release takes exactly NREGS edges
        reset_n = 1'b1;
        wait_ready(n);
        chk("init_clear_edges", 64'(n), 64'd32);
        check_all_zero("init_zero");

        // Write with same-edge forwarding, then plain read
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        tick();
        chk("fwd_r5", 64'(bus.rd_data), {32'h0, 32'hDEADBEEF});
        idle();
        set_rd(5'd5, 5'd5);
        tick();
        chk("read_r5_both", 64'(bus.rd_data), {32'hDEADBEEF, 32'hDEADBEEF});

        // Zero register ignores writes and busy sets
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h12345678;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        tick();
        chk("r0_data_same_edge", 64'(bus.rd_data), 64'h0);
        chk("r0_busy_same_edge", 64'(bus.rd_busy), 64'h0);
        idle();
        tick();
        chk("r0_data_after", 64'(bus.rd_data), 64'h0);
        chk("r0_busy_after", 64'(bus.rd_busy), 64'h0);

        // Scoreboard: set, hold, write clears, set beats write
        bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
        set_rd(5'd7, 5'd6);
        tick();
        chk("sb_set_r7", 64'(bus.rd_busy), 64'b01);
        idle();
        set_rd(5'd7, 5'd7);
        tick();
        chk("sb_hold_r7", 64'(bus.rd_busy), 64'b11);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h00000077;
        tick();
        chk("sb_wr_clear", 64'(bus.rd_busy), 64'b00);
        chk("sb_wr_data", 64'(bus.rd_data), {32'h77, 32'h77});
        bus.wr_data = 32'h0000A5A5; bus.busy_set = 1'b1; bus.busy_addr = 5'd7;
        tick();
        chk("sb_set_wins_busy", 64'(bus.rd_busy), 64'b11);
        chk("sb_set_wins_data", 64'(bus.rd_data), {32'hA5A5, 32'hA5A5});
        idle();
        tick();
        chk("sb_after_busy", 64'(bus.rd_busy), 64'b11);

        // Fill r1..r31, then flush with a colliding write
        for (int r = 1; r < NREGS; r++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'(r); bus.wr_data = 32'h10000000 | 32'(r);
            tick();
        end
        idle();
        set_rd(5'd1, 5'd31);
        tick();
        chk("fill_r1_r31", 64'(bus.rd_data), {32'h1000001F, 32'h10000001});

        bus.flush = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h00000BAD;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
        set_rd(5'd3, 5'd7);
        tick();
        chk("flush_ready_low", 64'(bus.ready), 64'h0);
        chk("flush_wr_dropped", 64'(bus.rd_data), {32'h10000007, 32'h10000003});
        chk("flush_busy_zero", 64'(bus.rd_busy), 64'h0);
        idle();

        // A second flush and writes during the clear are ignored
        n = 0;
        while (!bus.ready && n < BOUND) begin
            if (n == 5) begin
                bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 5'd3;
                bus.busy_set = 1'b1; bus.busy_addr = 5'd3;
            end else begin
                idle();
            end
            tick();
            n++;
            if (n == 8) begin
                chk("clear_read_data", 64'(bus.rd_data), 64'h0);
                chk("clear_read_busy", 64'(bus.rd_busy), 64'h0);
            end
        end
        idle();
        chk("flush_clear_edges", 64'(n), 64'd32);
        check_all_zero("flush_zero");

        // Reset during clear restarts the full sequence
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hCAFEF00D;
        tick();
        idle();
        bus.flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        reset_n = 1'b0;
        #2;
        chk("midclr_rst_ready", 64'(bus.ready), 64'h0);
        tick();
        reset_n = 1'b1;
        wait_ready(n);
        chk("midclr_clear_edges", 64'(n), 64'd32);
        set_rd(5'd5, 5'd0);
        tick();
        chk("midclr_r5_zero", 64'(bus.rd_data), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
